echo_response_checker: RTL and testbench

- Consumer end of the echo request path: the test driver enqueues 32-bit request values into the echo block, and this block receives the values echoed back.
- Two buffered streams are compared entry by entry: responses on the heard method and reference values on the expect method.
- Matches and mismatches are counted; pass/done/timeout status is flagged for the test top.
- Sits beside the echo driver in the test harness, on the response side of the echo block.

---
 rtl/echo_response_checker_if.sv | 28 ++
 rtl/echo_response_checker.sv | 197 +++++++++++++++++++
 tb/tb_echo_response_checker.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_response_checker_if.sv
// Purpose: heard (response) and expect (reference) push channels into the echo response checker.
// Latency: none; plain wires between the test driver and the checker.
// Backpressure: each channel has its own RDY; ENA is only legal while RDY=1.
//
// Signals:
//   heard__ENA / heard_v / heard__RDY    response push channel
//   expect__ENA / expect_v / expect__RDY reference push channel
// Modports: master = pushing side (test driver), slave = checker.
interface echo_response_checker_if #(
    parameter int WIDTH = 32
);
    logic             heard__ENA;
    logic [WIDTH-1:0] heard_v;
    logic             heard__RDY;
    logic             expect__ENA;
    logic [WIDTH-1:0] expect_v;
    logic             expect__RDY;

    modport master (
        output heard__ENA, heard_v, expect__ENA, expect_v,
        input  heard__RDY, expect__RDY
    );

    modport slave (
        input  heard__ENA, heard_v, expect__ENA, expect_v,
        output heard__RDY, expect__RDY
    );
endinterface

// File: rtl/echo_response_checker.sv
// Purpose: buffer echoed responses and reference values, compare them pairwise, count and flag results.
// Latency: pop-to-counter 1 cycle; done/pass visible in the same cycle as the final count.
// Backpressure: per-FIFO RDY = not full from registered occupancy; ENA while RDY=0 is dropped and
//               raises sticky protocol_err.
//
// Ports:
//   CLK, nRST          clock; asynchronous reset, active-high despite the name
//   bus (slave)        heard/expect push channels, see echo_response_checker_if
//   match_count        saturating count of equal compares
//   error_count        saturating count of unequal compares
//   done / pass        TOTAL compares finished / finished with no errors
//   timed_out          no pop for TIMEOUT cycles while running
//   protocol_err       sticky, ENA seen while the matching RDY was 0
// Optional (macro ECHO_CHECK_MISMATCH_LOG_EN):
//   first_bad_got / first_bad_exp / first_bad_index  values and 0-based ordinal of the first mismatch
module echo_response_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TOTAL   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                    CLK,
    input  logic                    nRST,
    echo_response_checker_if.slave  bus,
    output logic [15:0]             match_count,
    output logic [15:0]             error_count,
    output logic                    done,
    output logic                    pass,
    output logic                    timed_out,
    output logic                    protocol_err
`ifdef ECHO_CHECK_MISMATCH_LOG_EN
    ,
    output logic [WIDTH-1:0]        first_bad_got,
    output logic [WIDTH-1:0]        first_bad_exp,
    output logic [15:0]             first_bad_index
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t state, state_nxt;

    // Heard (response) FIFO
    logic [WIDTH-1:0] h_mem [DEPTH];
    logic [AW-1:0]    h_wp, h_rp;
    logic [CW-1:0]    h_cnt;
    logic             h_rdy, h_push;

    // Expect (reference) FIFO
    logic [WIDTH-1:0] e_mem [DEPTH];
    logic [AW-1:0]    e_wp, e_rp;
    logic [CW-1:0]    e_cnt;
    logic             e_rdy, e_push;

    logic             pop;
    logic             heads_eq;
    logic [16:0]      cmp_total;
    logic [16:0]      cmp_total_inc;
    logic [WDW-1:0]   wd;

    // RDY comes only from registered occupancy, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign h_rdy  = (h_cnt != CW'(DEPTH));
    assign e_rdy  = (e_cnt != CW'(DEPTH));
    assign h_push = bus.heard__ENA  && h_rdy;
    assign e_push = bus.expect__ENA && e_rdy;

    assign bus.heard__RDY  = h_rdy;
    assign bus.expect__RDY = e_rdy;

    assign heads_eq      = (h_mem[h_rp] == e_mem[e_rp]);
    assign cmp_total     = {1'b0, match_count} + {1'b0, error_count};
    assign cmp_total_inc = cmp_total + 17'd1;

    // Next state and pop decision
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (h_push || e_push) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                pop = (h_cnt != '0) && (e_cnt != '0);
                // Finishing the last compare moves to DONE on the same edge
                // that the final count lands, so done and the count agree.
                if (pop && (cmp_total_inc >= 17'(TOTAL))) begin
                    state_nxt = ST_DONE;
                end else if (!pop && (wd == WDW'(TIMEOUT - 1))) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            ST_DONE:    state_nxt = ST_DONE;
            ST_TIMEOUT: state_nxt = ST_TIMEOUT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge CLK) begin
        if (h_push) h_mem[h_wp] <= bus.heard_v;
        if (e_push) e_mem[e_wp] <= bus.expect_v;
    end

    // Pointers, occupancy, sticky protocol error
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            h_wp         <= '0;
            h_rp         <= '0;
            h_cnt        <= '0;
            e_wp         <= '0;
            e_rp         <= '0;
            e_cnt        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (h_push) h_wp <= h_wp + AW'(1);
            if (pop)    h_rp <= h_rp + AW'(1);
            if (h_push && !pop)      h_cnt <= h_cnt + CW'(1);
            else if (!h_push && pop) h_cnt <= h_cnt - CW'(1);

            if (e_push) e_wp <= e_wp + AW'(1);
            if (pop)    e_rp <= e_rp + AW'(1);
            if (e_push && !pop)      e_cnt <= e_cnt + CW'(1);
            else if (!e_push && pop) e_cnt <= e_cnt - CW'(1);

            if ((bus.heard__ENA && !h_rdy) || (bus.expect__ENA && !e_rdy)) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Compare counters and watchdog
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            match_count <= '0;
            error_count <= '0;
            wd          <= '0;
        end else begin
            if (pop) begin
                if (heads_eq) begin
                    if (match_count != 16'hFFFF) match_count <= match_count + 16'd1;
                end else begin
                    if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                end
            end

            if (state == ST_RUN && !pop) begin
                wd <= wd + WDW'(1);
            end else begin
                wd <= '0;
            end
        end
    end

`ifdef ECHO_CHECK_MISMATCH_LOG_EN
    logic bad_seen;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            bad_seen        <= 1'b0;
            first_bad_got   <= '0;
            first_bad_exp   <= '0;
            first_bad_index <= '0;
        end else if (pop && !heads_eq && !bad_seen) begin
            bad_seen        <= 1'b1;
            first_bad_got   <= h_mem[h_rp];
            first_bad_exp   <= e_mem[e_rp];
            // Ordinal of this compare = compares completed before it.
            first_bad_index <= cmp_total[15:0];
        end
    end
`endif

    assign done      = (state == ST_DONE);
    assign pass      = done && (error_count == 16'd0);
    assign timed_out = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_echo_response_checker.sv
module tb_echo_response_checker;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TOTAL   = 8;
    localparam int TIMEOUT = 16;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    echo_response_checker_if #(.WIDTH(WIDTH)) bus_if ();

    logic [15:0] match_count, error_count;
    logic        done, pass, timed_out, protocol_err;
`ifdef ECHO_CHECK_MISMATCH_LOG_EN
    logic [WIDTH-1:0] first_bad_got, first_bad_exp;
    logic [15:0]      first_bad_index;
`endif

    echo_response_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TOTAL(TOTAL), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .bus          (bus_if),
        .match_count  (match_count),
        .error_count  (error_count),
        .done         (done),
        .pass         (pass),
        .timed_out    (timed_out),
        .protocol_err (protocol_err)
`ifdef ECHO_CHECK_MISMATCH_LOG_EN
        ,
        .first_bad_got   (first_bad_got),
        .first_bad_exp   (first_bad_exp),
        .first_bad_index (first_bad_index)
`endif
    );

    initial forever #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queues hold what each FIFO holds; mode 0=idle 1=run 2=done 3=timeout.
    logic [31:0] mh[$];
    logic [31:0] me[$];
    int          m_mode, m_match, m_err, m_idle;
    bit          m_perr, m_logged;
    logic [31:0] m_bgot, m_bexp, m_bidx;
    bit          m_hr, m_er, m_pop, m_acc;

    task automatic model_reset();
        mh.delete();
        me.delete();
        m_mode = 0; m_match = 0; m_err = 0; m_idle = 0;
        m_perr = 0; m_logged = 0;
        m_bgot = 0; m_bexp = 0; m_bidx = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge nRST);
            if (nRST) begin
                model_reset();
            end else begin
                m_hr  = (mh.size() != DEPTH);
                m_er  = (me.size() != DEPTH);
                m_pop = (m_mode == 1) && (mh.size() > 0) && (me.size() > 0);
                if (m_pop) begin
                    if (mh[0] == me[0]) begin
                        if (m_match < 65535) m_match++;
                    end else begin
                        if (!m_logged) begin
                            m_logged = 1;
                            m_bgot = mh[0];
                            m_bexp = me[0];
                            m_bidx = 32'(m_match + m_err);
                        end
                        if (m_err < 65535) m_err++;
                    end
                    void'(mh.pop_front());
                    void'(me.pop_front());
                end
                m_acc = 0;
                if (bus_if.heard__ENA) begin
                    if (m_hr) begin mh.push_back(bus_if.heard_v); m_acc = 1; end
                    else m_perr = 1;
                end
                if (bus_if.expect__ENA) begin
                    if (m_er) begin me.push_back(bus_if.expect_v); m_acc = 1; end
                    else m_perr = 1;
                end
                if (m_mode == 0) begin
                    if (m_acc) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (m_pop) begin
                        m_idle = 0;
                        if (m_match + m_err >= TOTAL) m_mode = 2;
                    end else begin
                        m_idle++;
                        if (m_idle >= TIMEOUT) m_mode = 3;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial forever begin
        @(negedge CLK);
        chk("heard_rdy",    32'(bus_if.heard__RDY),  32'(mh.size() != DEPTH));
        chk("expect_rdy",   32'(bus_if.expect__RDY), 32'(me.size() != DEPTH));
        chk("match_count",  32'(match_count),        32'(m_match));
        chk("error_count",  32'(error_count),        32'(m_err));
        chk("done",         32'(done),               32'(m_mode == 2));
        chk("pass",         32'(pass),               32'((m_mode == 2) && (m_err == 0)));
        chk("timed_out",    32'(timed_out),          32'(m_mode == 3));
        chk("protocol_err", 32'(protocol_err),       32'(m_perr));
`ifdef ECHO_CHECK_MISMATCH_LOG_EN
        chk("first_bad_got",   32'(first_bad_got),   m_bgot);
        chk("first_bad_exp",   32'(first_bad_exp),   m_bexp);
        chk("first_bad_index", 32'(first_bad_index), m_bidx);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit he, input logic [31:0] hv, input bit ee, input logic [31:0] ev);
        bus_if.heard__ENA  = he;
        bus_if.heard_v     = hv;
        bus_if.expect__ENA = ee;
        bus_if.expect_v    = ev;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        nRST = 1'b1;
        step();
        step();
        nRST = 1'b0;
    endtask

    logic [31:0] t2_h [8];

    initial begin
        t2_h = '{32'd1, 32'd2, 32'd3, 32'd99, 32'd5, 32'd6, 32'd7, 32'd8};
        drive(0, 0, 0, 0);
        #1 nRST = 1'b1;
        #1;
        chk("rst_match",      32'(match_count),        32'd0);
        chk("rst_heard_rdy",  32'(bus_if.heard__RDY),  32'd1);
        chk("rst_expect_rdy", 32'(bus_if.expect__RDY), 32'd1);
        chk("rst_done",       32'(done),               32'd0);
        step();
        step();
        nRST = 1'b0;

        // T1: eight matching pairs of 22, expect/heard alternating
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) drive(0, 0, 1, 32'd22);
            else            drive(1, 32'd22, 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("t1_match_pre", 32'(match_count), 32'd7);
        chk("t1_done_pre",  32'(done),        32'd0);
        step();
        chk("t1_match", 32'(match_count), 32'd8);
        chk("t1_error", 32'(error_count), 32'd0);
        chk("t1_done",  32'(done),        32'd1);
        chk("t1_pass",  32'(pass),        32'd1);

        // T2: one mismatch at ordinal 3
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, t2_h[i], 1, 32'(i + 1));
            step();
        end
        drive(0, 0, 0, 0);
        chk("t2_match_pre", 32'(match_count), 32'd6);
        chk("t2_error_pre", 32'(error_count), 32'd1);
        step();
        chk("t2_match", 32'(match_count), 32'd7);
        chk("t2_error", 32'(error_count), 32'd1);
        chk("t2_done",  32'(done),        32'd1);
        chk("t2_pass",  32'(pass),        32'd0);
`ifdef ECHO_CHECK_MISMATCH_LOG_EN
        chk("t2_bad_got", 32'(first_bad_got),   32'd99);
        chk("t2_bad_exp", 32'(first_bad_exp),   32'd4);
        chk("t2_bad_idx", 32'(first_bad_index), 32'd3);
`endif

        // T3: overfill the heard FIFO
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(40 + i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("t3_rdy_full",  32'(bus_if.heard__RDY), 32'd0);
        chk("t3_perr_pre",  32'(protocol_err),      32'd0);
        drive(1, 32'd77, 0, 0);
        step();
        drive(0, 0, 0, 0);
        chk("t3_perr",      32'(protocol_err),      32'd1);
        chk("t3_rdy_still", 32'(bus_if.heard__RDY), 32'd0);

        // T4: expects only -> watchdog expiry
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'(i + 1));
            step();
        end
        drive(0, 0, 0, 0);
        repeat (13) step();
        chk("t4_tmo_pre", 32'(timed_out), 32'd0);
        step();
        chk("t4_tmo",  32'(timed_out), 32'd1);
        chk("t4_done", 32'(done),      32'd0);
        chk("t4_pass", 32'(pass),      32'd0);

        // T5: full heard FIFO, RDY timing around pop, push+pop same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(10 + i), 0, 0);
            step();
        end
        drive(0, 0, 1, 32'd10);
        step();
        drive(0, 0, 0, 0);
        chk("t5_rdy_in_pop", 32'(bus_if.heard__RDY), 32'd0);
        step();
        chk("t5_rdy_after",  32'(bus_if.heard__RDY), 32'd1);
        chk("t5_match1",     32'(match_count),       32'd1);
        drive(0, 0, 1, 32'd11);
        step();
        drive(1, 32'd14, 1, 32'd12);
        step();
        drive(0, 0, 0, 0);
        chk("t5_match2",   32'(match_count),        32'd2);
        chk("t5_hrdy",     32'(bus_if.heard__RDY),  32'd1);
        chk("t5_erdy",     32'(bus_if.expect__RDY), 32'd1);
        step();
        chk("t5_match3",   32'(match_count), 32'd3);
        chk("t5_error3",   32'(error_count), 32'd0);

        // T6: asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(100 + i), 1, 32'(100 + i));
            step();
        end
        drive(0, 0, 0, 0);
        step();
        chk("t6_match5", 32'(match_count), 32'd5);
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0);
        chk("t6_rdy_full", 32'(bus_if.heard__RDY), 32'd0);
        #2 nRST = 1'b1;
        #1;
        chk("t6_async_match",  32'(match_count),        32'd0);
        chk("t6_async_hrdy",   32'(bus_if.heard__RDY),  32'd1);
        chk("t6_async_erdy",   32'(bus_if.expect__RDY), 32'd1);
        chk("t6_async_done",   32'(done),               32'd0);
        step();
        step();
        nRST = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
